frame_sink: RTL and testbench

- Consumer end of the renderer pixel stream (coords_out/color_out/render_done/render_ack).
- Owns a double-buffered 320x240x3-bit framebuffer: captures one pixel per cycle into the back buffer, waits for vertical sync, swaps buffers, then re-arms the renderer with a one-cycle ack.
- Concurrently serves the VGA scan-out with 2x pixel doubling from the front buffer.

---
 rtl/frame_sink_pkg.sv | 38 +++
 rtl/frame_sink_fb_ram.sv | 42 ++++
 rtl/frame_sink.sv | 170 +++++++++++++++++
 tb/tb_frame_sink.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_sink_pkg
// Description : Shared types for the frame sink. Holds the renderer screen
//               coordinate struct, framebuffer geometry constants, the
//               17-bit framebuffer offset type, the sink state encoding and
//               the y*320+x offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_sink_pkg;

  localparam int C_FB_W  = 320;
  localparam int C_FB_H  = 240;
  localparam int C_FB_AW = 17;

  // Renderer pixel coordinate: x 0..319 (9b), y 0..239 (8b).
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } screenXY;

  typedef logic [C_FB_AW-1:0] fb_addr_t;

  typedef enum logic [2:0] {
    ARM        = 3'd0,
    CAPTURE    = 3'd1,
    WAIT_DONE  = 3'd2,
    WAIT_VSYNC = 3'd3,
    SWAP       = 3'd4
  } sink_state_t;

  // Offset within one buffer: y*320 + x built from shifts, (y<<8)+(y<<6)+x.
  function automatic fb_addr_t fb_addr(input logic [8:0] x, input logic [8:0] y);
    return {y, 8'h00} + {2'b00, y, 6'h00} + {8'h00, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sink_fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_sink_fb_ram
// Description : Simple dual-port framebuffer RAM, one write port and one
//               registered read port. The MSB of each address selects the
//               buffer; the low bits are the 17-bit offset inside it.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - {buffer, offset} write address
//               i_wdata  - write pixel
//               i_raddr  - {buffer, offset} read address
//               o_rdata  - read pixel, one cycle after i_raddr
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sink_fb_ram #(
  parameter int COLOR_W = 3,
  parameter int AW      = 18
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [COLOR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [COLOR_W-1:0] o_rdata
);

  // Each half spans the full 17-bit offset range so the buffer bit can be a
  // plain address prefix; only the first 76800 entries of a half hold pixels.
  logic [COLOR_W-1:0] r_mem [0:(1<<AW)-1];
  logic [COLOR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/frame_sink.sv
`default_nettype none
// ============================================================================
// Module      : frame_sink
// Description : Consumer end of the renderer pixel stream. Captures one pixel
//               per cycle into the back buffer, waits for vertical sync,
//               swaps buffers and re-arms the renderer with a one-cycle ack.
//               Concurrently scans the front buffer out to VGA with 2x pixel
//               doubling.
// Ports       : Clk, Reset_n          - clock, synchronous active-low reset
//               coords_in, color_in   - renderer pixel stream
//               render_done           - renderer end-of-frame pulse
//               render_ack            - start-frame pulse to renderer
//               DrawX, DrawY, vsync_n - VGA raster position and sync
//               pixel_color           - scan-out colour (2-cycle latency)
//               front_sel             - buffer being displayed
//               frame_count           - completed swaps, wraps
//               sync_err              - sticky protocol-error flag
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sink
  import frame_sink_pkg::*;
#(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int COLOR_W = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  screenXY            coords_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               render_done,
  output logic               render_ack,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               vsync_n,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               front_sel,
  output logic [7:0]         frame_count,
  output logic               sync_err
);

  localparam logic [8:0] C_X_LIM  = 9'(FB_W);
  localparam logic [8:0] C_Y_LIM  = 9'(FB_H);
  localparam logic [8:0] C_X_LAST = 9'(FB_W - 1);
  localparam logic [8:0] C_Y_LAST = 9'(FB_H - 1);

  sink_state_t        r_state, w_next;
  logic               r_ack;
  logic               r_front;
  logic [7:0]         r_count;
  logic               r_err;
  logic               r_vs_prev;
  logic               r_vs_pend;
  logic [1:0]         r_to;
  logic               r_blank_d;
  logic [COLOR_W-1:0] r_pix;

  logic               w_capture;
  logic               w_in_range;
  logic               w_last;
  logic               w_fall;
  logic               w_timeout;
  logic               w_err_set;
  logic               w_we;
  logic [17:0]        w_waddr;
  logic [17:0]        w_raddr;
  logic [COLOR_W-1:0] w_rdata;

  assign w_capture  = (r_state == CAPTURE);
  assign w_in_range = (coords_in.x < C_X_LIM) && ({1'b0, coords_in.y} < C_Y_LIM);
  assign w_last     = w_capture && (coords_in.x == C_X_LAST) &&
                      ({1'b0, coords_in.y} == C_Y_LAST);
  assign w_fall     = r_vs_prev && !vsync_n;
  assign w_timeout  = (r_state == WAIT_DONE) && !render_done && (r_to == 2'd3);
  assign w_err_set  = (w_capture && (render_done || !w_in_range)) || w_timeout;

  // Writes always go to the back buffer, reads to the front, so the two
  // ports never touch the same half.
  assign w_we    = Reset_n && w_capture && w_in_range;
  assign w_waddr = {~r_front, fb_addr(coords_in.x, {1'b0, coords_in.y})};
  assign w_raddr = {r_front, fb_addr(DrawX[9:1], DrawY[9:1])};

  // ARM holds for two cycles only after reset (ack low, then ack high); when
  // entered from SWAP the ack is already raised on entry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARM:        if (r_ack) w_next = CAPTURE;
      CAPTURE:    if (w_last) w_next = WAIT_DONE;
      WAIT_DONE:  if (render_done || w_timeout) w_next = WAIT_VSYNC;
      WAIT_VSYNC: if (w_fall || r_vs_pend) w_next = SWAP;
      SWAP:       w_next = ARM;
      default:    w_next = ARM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= ARM;
      r_ack     <= 1'b0;
      r_front   <= 1'b0;
      r_count   <= 8'd0;
      r_err     <= 1'b0;
      r_vs_prev <= 1'b1;
      r_vs_pend <= 1'b0;
      r_to      <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_ack     <= (w_next == ARM) && !r_ack;
      r_vs_prev <= vsync_n;

      if (w_err_set) begin
        r_err <= 1'b1;
      end

      if (r_state == WAIT_DONE) begin
        r_to <= r_to + 2'd1;
      end else begin
        r_to <= 2'd0;
      end

      if (r_state == SWAP) begin
        r_front <= ~r_front;
        r_count <= r_count + 8'd1;
      end

      // An edge landing on the WAIT_DONE exit cycle is remembered so the
      // swap still happens; stale edges are dropped when a capture starts.
      if ((r_state == ARM) && (w_next == CAPTURE)) begin
        r_vs_pend <= 1'b0;
      end else if ((r_state == WAIT_VSYNC) && (w_next == SWAP)) begin
        r_vs_pend <= 1'b0;
      end else if ((r_state == WAIT_DONE) && (w_next == WAIT_VSYNC) && w_fall) begin
        r_vs_pend <= 1'b1;
      end
    end
  end

  // Scan-out: RAM read stage, then output register; blanking is delayed by
  // one cycle to line up with the RAM data.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_blank_d <= 1'b1;
      r_pix     <= '0;
    end else begin
      r_blank_d <= (DrawX >= 10'd640) || (DrawY >= 10'd480);
      r_pix     <= r_blank_d ? '0 : w_rdata;
    end
  end

  frame_sink_fb_ram #(
    .COLOR_W (COLOR_W),
    .AW      (18)
  ) u_fb_ram (
    .clk     (Clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (color_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign render_ack  = r_ack;
  assign pixel_color = r_pix;
  assign front_sel   = r_front;
  assign frame_count = r_count;
  assign sync_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sink
// Description : Directed self-checking bench for frame_sink. Plays the
//               renderer and VGA timing roles with short frames that always
//               finish on coordinate (319,239).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_sink;
  import frame_sink_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n;
  screenXY    coords_in;
  logic [2:0] color_in;
  logic       render_done;
  logic       render_ack;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       vsync_n;
  logic [2:0] pixel_color;
  logic       front_sel;
  logic [7:0] frame_count;
  logic       sync_err;

  int n_checks = 0;
  int n_errors = 0;

  frame_sink #(
    .FB_W    (320),
    .FB_H    (240),
    .COLOR_W (3)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .coords_in   (coords_in),
    .color_in    (color_in),
    .render_done (render_done),
    .render_ack  (render_ack),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .vsync_n     (vsync_n),
    .pixel_color (pixel_color),
    .front_sel   (front_sel),
    .frame_count (frame_count),
    .sync_err    (sync_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic put_px(input int x, input int y, input logic [2:0] c, input logic done);
    coords_in.x = 9'(x);
    coords_in.y = 8'(y);
    color_in    = c;
    render_done = done;
    step();
    render_done = 1'b0;
    coords_in   = '0;
    color_in    = '0;
  endtask

  // Rows 0..rows-1 in raster order, colour = x^y^salt. Optionally drops
  // vsync_n for one cycle at (vs_x,vs_y) and injects an out-of-range pixel
  // (320,0) right after (0,inj_y).
  task automatic raster(input int rows, input int salt, input int vs_x, input int vs_y,
                        input int inj_y);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < 320; x++) begin
        vsync_n = !((x == vs_x) && (y == vs_y));
        put_px(x, y, 3'(x ^ y ^ salt), 1'b0);
        vsync_n = 1'b1;
        if ((x == 0) && (y == inj_y)) put_px(320, 0, 3'd7, 1'b0);
      end
    end
  endtask

  task automatic finish_frame(input int salt);
    put_px(319, 239, 3'(319 ^ 239 ^ salt), 1'b0);
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    repeat (3) step();
  endtask

  task automatic scan(input string tag, input int dx, input int dy, input int exp);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check(tag, 32'(pixel_color), 32'(exp));
    DrawX = 10'd700;
    DrawY = 10'd500;
  endtask

  task automatic do_vsync(input string tag, input int exp_front, input int exp_count);
    vsync_n = 1'b0;
    step();
    check({tag, "_ack_early"}, 32'(render_ack), 0);
    step();
    check({tag, "_ack"}, 32'(render_ack), 1);
    check({tag, "_front"}, 32'(front_sel), 32'(exp_front));
    check({tag, "_count"}, 32'(frame_count), 32'(exp_count));
    vsync_n = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (render_ack !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(render_ack), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n     = 1'b0;
    vsync_n     = 1'b1;
    coords_in   = '0;
    color_in    = '0;
    render_done = 1'b0;
    DrawX       = 10'd700;
    DrawY       = 10'd500;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_ack", 32'(render_ack), 0);
    check("rst_pix", 32'(pixel_color), 0);
    check("rst_front", 32'(front_sel), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_err", 32'(sync_err), 0);

    // Release: ack one cycle after the first unreset edge, one cycle wide.
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    check("ack_before", 32'(render_ack), 0);
    step();
    check("ack_pulse", 32'(render_ack), 1);
    step();
    check("ack_width", 32'(render_ack), 0);

    // Frame 1 into buffer 1, salt 0.
    raster(10, 0, -1, -1, -1);
    finish_frame(0);
    check("f1_err", 32'(sync_err), 0);
    do_vsync("f1", 1, 1);
    scan("f1_px_6_4", 13, 9, 2);
    scan("f1_px_5_3", 10, 6, 6);
    scan("f1_blank", 660, 12, 0);

    // Frame 2 into buffer 0, salt 5, vsync edge mid-capture is ignored.
    raster(10, 5, 50, 2, -1);
    finish_frame(5);
    check("f2_noswap_front", 32'(front_sel), 1);
    check("f2_noswap_count", 32'(frame_count), 1);
    check("f2_err", 32'(sync_err), 0);
    scan("f2_old_px", 13, 9, 2);
    do_vsync("f2", 0, 2);
    scan("f2_new_px", 13, 9, 7);

    // Frame 3 into buffer 1, salt 3: render_done mid-capture, then a vsync
    // edge on the same cycle WAIT_DONE exits.
    raster(10, 3, -1, -1, -1);
    put_px(100, 50, 3'(100 ^ 50 ^ 3), 1'b1);
    check("f3_err_mid", 32'(sync_err), 1);
    put_px(319, 239, 3'(319 ^ 239 ^ 3), 1'b0);
    render_done = 1'b1;
    vsync_n     = 1'b0;
    step();
    render_done = 1'b0;
    step();
    vsync_n = 1'b1;
    wait_ack("f3_pend_ack");
    check("f3_front", 32'(front_sel), 1);
    check("f3_count", 32'(frame_count), 3);
    scan("f3_px", 13, 9, 1);

    // Frame 4: reset pulse while capturing (200,120).
    raster(2, 1, -1, -1, -1);
    coords_in.x = 9'd200;
    coords_in.y = 8'd120;
    color_in    = 3'd1;
    Reset_n     = 1'b0;
    step();
    Reset_n = 1'b1;
    @(negedge Clk);
    check("f4_rst_front", 32'(front_sel), 0);
    check("f4_rst_count", 32'(frame_count), 0);
    check("f4_rst_err", 32'(sync_err), 0);
    check("f4_rst_ack", 32'(render_ack), 0);
    step();
    check("f4_rearm_ack", 32'(render_ack), 1);
    step();

    // Frame 5 into buffer 1, salt 4, with (320,0) injected after (0,1).
    raster(10, 4, -1, -1, 1);
    check("f5_oor_err", 32'(sync_err), 1);
    finish_frame(4);
    do_vsync("f5", 1, 1);
    scan("f5_px_0_0", 0, 0, 4);
    scan("f5_px_0_1", 1, 3, 5);
    scan("f5_px_6_4", 13, 9, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
